// File: rtl/trigger_tag_pkg.sv
// Shared widths and the tag record for the L1 trigger tag FIFO.
// The tag is the voted L1 ID, the BC count and the BC error flag captured on a trigger.
package trigger_tag_pkg;

    localparam int BC_W_DEF       = 8;
    localparam int L1ID_W_DEF     = 5;
    localparam int DEPTH_LOG2_DEF = 4;

    typedef struct packed {
        logic [L1ID_W_DEF-1:0] l1id;
        logic [BC_W_DEF-1:0]   bc;
        logic                  bc_err;
    } trig_tag_t;

endpackage

// File: rtl/trigger_tag_fifo_l1id_tmr_counter.sv
// Triple-redundant L1 trigger ID counter with a per-bit majority voter.
// Every edge rewrites all three copies from the voted value, so a single upset copy heals in one cycle.
module l1id_tmr_counter
    import trigger_tag_pkg::*;
#(
    parameter int L1ID_W = L1ID_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              trigger_i,
    input  logic              clear_i,
    output logic [L1ID_W-1:0] tag_l1id_o,
    output logic              error_o
);

    logic [L1ID_W-1:0] cnt0_q, cnt1_q, cnt2_q;
    logic [L1ID_W-1:0] cnt_d;
    logic [L1ID_W-1:0] voted;
    logic              error_q, error_d;

    assign voted = (cnt0_q & cnt1_q) | (cnt0_q & cnt2_q) | (cnt1_q & cnt2_q);

    always_comb begin
        cnt_d = voted;
        if (clear_i) begin
            cnt_d = trigger_i ? L1ID_W'(1) : '0;
        end else if (trigger_i) begin
            cnt_d = voted + L1ID_W'(1);
        end
    end

    assign error_d = (cnt0_q != cnt1_q) || (cnt1_q != cnt2_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            error_q <= 1'b0;
        end else begin
            cnt0_q  <= cnt_d;
            cnt1_q  <= cnt_d;
            cnt2_q  <= cnt_d;
            error_q <= error_d;
        end
    end

    // An event counter reset coinciding with a trigger tags that trigger as ID 0.
    assign tag_l1id_o = clear_i ? '0 : voted;
    assign error_o    = error_q;

endmodule

// File: rtl/trigger_tag_fifo.sv
// Captures {L1 ID, BC, BC error} on every L1 trigger into a show-ahead FIFO for the readout stage.
// Head fields come straight from registered storage, so no input reaches an output combinationally.
module trigger_tag_fifo
    import trigger_tag_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int L1ID_W     = L1ID_W_DEF,
    parameter int BC_W       = BC_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Trigger,
    input  logic              ClearL1ID,
    input  logic [BC_W-1:0]   BC,
    input  logic              BCError,
    input  logic              Pop,
    output logic              TagValid,
    output logic [BC_W-1:0]   TagBC,
    output logic [L1ID_W-1:0] TagL1ID,
    output logic              TagBCErr,
    output logic              Full,
    output logic              Overflow,
    output logic              L1IDError
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TAG_W = L1ID_W + BC_W + 1;

    logic [TAG_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q;
    logic                  empty, full;
    logic                  push_ok, pop_ok, drop;
    logic [L1ID_W-1:0]     tag_l1id;
    logic [TAG_W-1:0]      head;

    l1id_tmr_counter #(.L1ID_W(L1ID_W)) u_l1id (
        .clk_i      (Clk),
        .rst_n_i    (Reset),
        .trigger_i  (Trigger),
        .clear_i    (ClearL1ID),
        .tag_l1id_o (tag_l1id),
        .error_o    (L1IDError)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign pop_ok  = Pop && !empty;
    assign push_ok = Trigger && (!full || pop_ok);
    assign drop    = Trigger && full && !pop_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_d;
            // A drop on the same edge as an ECR is a fresh loss and must stay visible.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ClearL1ID) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {tag_l1id, BC, BCError};
    end

    assign head     = empty ? '0 : mem_q[rd_ptr_q];
    assign TagValid = !empty;
    assign TagL1ID  = head[TAG_W-1 -: L1ID_W];
    assign TagBC    = head[BC_W:1];
    assign TagBCErr = head[0];
    assign Full     = full;
    assign Overflow = overflow_q;

endmodule

// File: doc/trigger_tag_fifo.md
# trigger_tag_fifo

Downstream consumer of the bunch-crossing counter in the FE-I4 emulator. On every Level-1 trigger it captures the current voted 8-bit BC value and the BC counter error flag. It tags the capture with a triple-redundant L1 trigger ID and queues the tag in a small show-ahead FIFO. The readout/data-header stage drains tags in trigger order.

## Interface
Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries
- L1ID_W, 5, L1 trigger ID width
- BC_W, 8, BC value width (matches BC counter)

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Trigger  in  1  L1 trigger, one trigger per cycle it is high
- ClearL1ID  in  1  event counter reset (ECR), synchronous
- BC  in  BC_W  voted BC count (updated on falling edge upstream, stable at rising edge)
- BCError  in  1  BC counter redundancy error
- Pop  in  1  consume head tag; ignored when TagValid low
- TagValid  out  1  FIFO not empty
- TagBC  out  BC_W  head tag BC value
- TagL1ID  out  L1ID_W  head tag L1 ID
- TagBCErr  out  1  BCError captured with head tag
- Full  out  1  FIFO holds 2**DEPTH_LOG2 tags
- Overflow  out  1  sticky: a trigger was dropped
- L1IDError  out  1  L1 ID copies disagreed at last rising edge

## Operation
- Reset: FIFO empty, pointers 0, L1 ID copies 0, Overflow 0, L1IDError 0. TagValid, Full, TagBC, TagL1ID and TagBCErr are all 0.
- Tag = {L1ID_voted, BC, BCError}, captured at the rising edge where Trigger=1.
- Write: if Trigger and (not Full, or Pop accepted the same edge), store the tag and advance the write pointer.
- Drop: if Trigger and Full and no Pop, do not store the tag. Set Overflow. The L1 ID still increments, so downstream sees a gap in the ID sequence.
- L1 ID counter:
  - Three copies, majority voted per bit.
  - Each copy loads voted+1 on Trigger.
  - The counter wraps modulo 2**L1ID_W.
- ClearL1ID:
  - All three copies go to 0 and Overflow is cleared. FIFO contents are retained.
  - If Trigger coincides with ClearL1ID, the stored tag carries L1ID 0 and the counter becomes 1.
- Read: Pop with TagValid=1 advances the read pointer. Pop with TagValid=0 has no effect.
- Push and pop on the same edge: occupancy is unchanged. On an empty FIFO a simultaneous Pop is ignored, so occupancy becomes 1.
- Outputs:
  - TagValid = (count != 0).
  - Full = (count == 2**DEPTH_LOG2).
  - Tag fields show the head entry and are forced to 0 when TagValid=0.
- L1IDError: registered at each rising edge. Set to 1 if the three copies are not all equal, else 0. Not sticky.
- Arithmetic:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - Count is DEPTH_LOG2+1 bits.
- Reset asserted mid-operation discards all queued tags immediately, since the reset is asynchronous.

## Timing
- Trigger at edge N on an empty FIFO: TagValid=1 and the tag fields are valid after edge N (available to the consumer before edge N+1).
- Pop at edge N: the next head entry (or TagValid=0) appears after edge N.
- Full and Overflow update at the same edge as the write or drop.
- L1IDError lags a copy disagreement by one rising edge.
- BC is sampled only at rising edges, half a cycle after the upstream falling-edge update.
- No combinational path from Trigger or Pop to any output.

## Structure
- Package trigger_tag_pkg: BC_W and L1ID_W defaults, plus a packed typedef trig_tag_t {l1id, bc, bc_err}.
- Sub-module l1id_tmr_counter: three copies, voter, clear/increment and L1IDError register.
- The top level holds the memory array, pointers, count, Overflow and output gating.

## Test plan
- Reset, then triggers at 3 consecutive edges with BC=0x10,0x11,0x12 → three tags L1ID 0,1,2 with matching BC. TagValid=1 until the third Pop.
- 17 triggers with no Pop (DEPTH_LOG2=4) → Full after the 16th. On the 17th, Overflow=1, L1ID advances to 17, FIFO unchanged. Pop all 16 → L1IDs 0..15.
- Full FIFO with Trigger+Pop on the same edge → head advances, new tag stored, Full stays 1, Overflow stays 0.
- Trigger with ClearL1ID when the counter is 9 → stored tag L1ID 0. The next trigger is tagged 1, and Overflow is cleared.
- 40 triggers with sparse pops → L1ID wraps 31→0. Force one counter copy to differ → tags still carry the voted value, and L1IDError=1 for one cycle after the edge.
- Trigger with BCError=1, then assert Reset mid-stream → the tag carries TagBCErr=1. After Reset, TagValid=0, all outputs 0, and the next tag is L1ID 0.
